// File: rtl/mem_access_unit.sv
// Memory access unit: arbitrates instruction fetch and load/store onto a
// word-addressed RAM port whose writes are triggered by data changes.
module mem_access_unit #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDRESS_SIZE-1:0] if_addr,
    output logic                    if_valid,
    output logic [DATA_SIZE-1:0]    if_instr,
    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [ADDRESS_SIZE-1:0] ls_addr,
    input  logic [DATA_SIZE-1:0]    ls_wdata,
    output logic                    ls_done,
    output logic [DATA_SIZE-1:0]    ls_rdata,
    output logic                    ready,
    output logic                    ram_read_write,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    output logic [DATA_SIZE-1:0]    ram_data_in,
    input  logic [DATA_SIZE-1:0]    ram_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_DATA
    } state_t;

    state_t                  state_q, state_d;
    logic                    is_fetch_q, is_fetch_d;
    logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
    logic                    ram_rw_q, ram_rw_d;
    logic [ADDRESS_SIZE-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_SIZE-1:0]    ram_din_q, ram_din_d;
    logic                    if_valid_q, if_valid_d;
    logic [DATA_SIZE-1:0]    if_instr_q, if_instr_d;
    logic                    ls_done_q, ls_done_d;
    logic [DATA_SIZE-1:0]    ls_rdata_q, ls_rdata_d;
    logic                    ready_q, ready_d;

    // Next-state and next-output logic; every output comes from a register.
    always_comb begin
        state_d    = state_q;
        is_fetch_d = is_fetch_q;
        wdata_d    = wdata_q;
        ram_rw_d   = ram_rw_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if_valid_d = 1'b0;
        if_instr_d = if_instr_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            IDLE: begin
                ram_rw_d = 1'b1;
                if (ls_req) begin
                    ram_addr_d = ls_addr;
                    is_fetch_d = 1'b0;
                    if (ls_we) begin
                        // Writing the complement first forces a data change
                        // even when the store data equals the current data_in.
                        ram_rw_d  = 1'b0;
                        ram_din_d = ~ls_wdata;
                        wdata_d   = ls_wdata;
                        state_d   = WR_SETUP;
                    end else begin
                        state_d = RD;
                    end
                end else if (if_req) begin
                    ram_addr_d = if_addr;
                    is_fetch_d = 1'b1;
                    state_d    = RD;
                end
            end
            RD: begin
                if (is_fetch_q) begin
                    if_instr_d = ram_data_out;
                    if_valid_d = 1'b1;
                end else begin
                    ls_rdata_d = ram_data_out;
                    ls_done_d  = 1'b1;
                end
                state_d = IDLE;
            end
            WR_SETUP: begin
                ram_din_d = wdata_q;
                state_d   = WR_DATA;
            end
            WR_DATA: begin
                // Address and data stay put while the port returns to read.
                ram_rw_d  = 1'b1;
                ls_done_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                ram_rw_d = 1'b1;
                state_d  = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_fetch_q <= 1'b0;
            wdata_q    <= '0;
            ram_rw_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= '0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            is_fetch_q <= is_fetch_d;
            wdata_q    <= wdata_d;
            ram_rw_q   <= ram_rw_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
            ready_q    <= ready_d;
        end
    end

    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign ls_done        = ls_done_q;
    assign ls_rdata       = ls_rdata_q;
    assign ready          = ready_q;
    assign ram_read_write = ram_rw_q;
    assign ram_address    = ram_addr_q;
    assign ram_data_in    = ram_din_q;

endmodule
